// File: rtl/thr_ex_handler.sv
// Per-thread exception handler: captures a stalled thread's exception, reports it to the
// host as a header beat plus an EPC beat, then clears or parks the thread on command.
module thr_ex_handler #(
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF,
  parameter logic [1:0]  HDR_TAG     = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_stall,
  input  logic [5:0]  ex_code,
  input  logic [7:0]  thr_id,
  input  logic [31:0] epc,
  output logic        rep_valid,
  output logic [31:0] rep_data,
  input  logic        rep_ready,
  input  logic        resume,
  input  logic        kill,
  output logic        clr_ex,
  output logic        thr_killed,
  output logic [15:0] ex_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEND_HDR = 3'd1;
  localparam logic [2:0] S_SEND_EPC = 3'd2;
  localparam logic [2:0] S_WAIT_CMD = 3'd3;
  localparam logic [2:0] S_CLEAR    = 3'd4;
  localparam logic [2:0] S_KILLED   = 3'd5;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [5:0]  ex_code_cap;
  logic [7:0]  thr_id_cap;
  logic [31:0] epc_cap;
  logic [15:0] wd_cnt;
  logic        wd_expire;

  // Report channel: a beat transfers on a cycle where rep_valid && rep_ready; while
  // rep_valid is high, rep_data is held stable and rep_valid is not withdrawn.

  // wd_cnt holds the number of WAIT_CMD cycles already completed, so the limit is hit
  // at the end of the TIMEOUT_CYC-th cycle.
  assign wd_expire = (TIMEOUT_CYC != 16'd0) && (wd_cnt == TIMEOUT_CYC - 16'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (csr_stall) state_nxt = S_SEND_HDR;
      S_SEND_HDR: if (rep_ready) state_nxt = S_SEND_EPC;
      S_SEND_EPC: if (rep_ready) state_nxt = S_WAIT_CMD;
      S_WAIT_CMD: begin
        if (kill)           state_nxt = S_KILLED;
        else if (resume)    state_nxt = S_CLEAR;
        else if (wd_expire) state_nxt = S_KILLED;
      end
      S_CLEAR:    state_nxt = S_IDLE;
      S_KILLED:   state_nxt = S_KILLED;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ex_code_cap <= 6'd0;
      thr_id_cap  <= 8'd0;
      epc_cap     <= 32'd0;
      wd_cnt      <= 16'd0;
      ex_cnt      <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && csr_stall) begin
        ex_code_cap <= ex_code;
        thr_id_cap  <= thr_id;
        epc_cap     <= epc;
      end
      if (state == S_SEND_HDR && rep_ready && ex_cnt != 16'hFFFF)
        ex_cnt <= ex_cnt + 16'd1;
      if (state == S_WAIT_CMD) wd_cnt <= wd_cnt + 16'd1;
      else                     wd_cnt <= 16'd0;
    end
  end

  // Outputs decode from registered state only, so reset drops them asynchronously.
  always_comb begin
    rep_data = 32'd0;
    case (state)
      S_SEND_HDR: rep_data = {HDR_TAG, thr_id_cap, ex_code_cap, ex_cnt};
      S_SEND_EPC: rep_data = epc_cap;
      default:    rep_data = 32'd0;
    endcase
  end

  assign rep_valid  = (state == S_SEND_HDR) || (state == S_SEND_EPC);
  assign clr_ex     = (state == S_CLEAR);
  assign thr_killed = (state == S_KILLED);

endmodule

// File: tb/tb_thr_ex_handler.sv
// Bench for thr_ex_handler: two instances (watchdog of 8 and watchdog disabled) share
// stimulus; a transaction-level model is compared every cycle plus literal spot checks.
module tb_thr_ex_handler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_stall;
  logic [5:0]  ex_code;
  logic [7:0]  thr_id;
  logic [31:0] epc;
  logic        rep_ready;
  logic        resume;
  logic        kill;

  logic        a_rep_valid, a_clr_ex, a_thr_killed;
  logic [31:0] a_rep_data;
  logic [15:0] a_ex_cnt;
  logic        b_rep_valid, b_clr_ex, b_thr_killed;
  logic [31:0] b_rep_data;
  logic [15:0] b_ex_cnt;

  int n_checks = 0;
  int n_errors = 0;

  thr_ex_handler #(.TIMEOUT_CYC(16'd8), .HDR_TAG(2'b10)) dut_a (
    .clk(clk), .rst_n(rst_n), .csr_stall(csr_stall), .ex_code(ex_code), .thr_id(thr_id),
    .epc(epc), .rep_valid(a_rep_valid), .rep_data(a_rep_data), .rep_ready(rep_ready),
    .resume(resume), .kill(kill), .clr_ex(a_clr_ex), .thr_killed(a_thr_killed),
    .ex_cnt(a_ex_cnt)
  );

  thr_ex_handler #(.TIMEOUT_CYC(16'd0), .HDR_TAG(2'b10)) dut_b (
    .clk(clk), .rst_n(rst_n), .csr_stall(csr_stall), .ex_code(ex_code), .thr_id(thr_id),
    .epc(epc), .rep_valid(b_rep_valid), .rep_data(b_rep_data), .rep_ready(rep_ready),
    .resume(resume), .kill(kill), .clr_ex(b_clr_ex), .thr_killed(b_thr_killed),
    .ex_cnt(b_ex_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: report progress tracked as beats sent / waiting ----------------
  typedef struct {
    bit          killed;
    bit          busy;
    bit          clearing;
    int          beats;
    int          wait_cyc;
    int          cnt;
    logic [5:0]  code;
    logic [7:0]  tid;
    logic [31:0] pc;
  } model_t;

  model_t m[2];
  int     to_cyc[2] = '{8, 0};

  function automatic model_t fresh();
    model_t s;
    s.killed = 0; s.busy = 0; s.clearing = 0; s.beats = 0; s.wait_cyc = 0; s.cnt = 0;
    s.code = '0; s.tid = '0; s.pc = '0;
    return s;
  endfunction

  function automatic model_t step(input model_t s, input int to);
    if (s.killed) begin
    end else if (s.clearing) begin
      s.clearing = 0;
    end else if (!s.busy) begin
      if (csr_stall) begin
        s.busy = 1; s.beats = 0; s.code = ex_code; s.tid = thr_id; s.pc = epc;
      end
    end else if (s.beats < 2) begin
      if (rep_ready) begin
        if (s.beats == 0 && s.cnt < 65535) s.cnt++;
        s.beats++;
        s.wait_cyc = 0;
      end
    end else if (kill) begin
      s.busy = 0; s.killed = 1;
    end else if (resume) begin
      s.busy = 0; s.clearing = 1;
    end else begin
      s.wait_cyc++;
      if (to != 0 && s.wait_cyc == to) begin
        s.busy = 0; s.killed = 1;
      end
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] = fresh();
      m[1] = fresh();
    end else begin
      m[0] = step(m[0], to_cyc[0]);
      m[1] = step(m[1], to_cyc[1]);
    end
  end

  task automatic cmp_model(input int i, input logic v, input logic [31:0] d, input logic c,
                           input logic k, input logic [15:0] n);
    logic        ev;
    logic [31:0] ed;
    ev = m[i].busy && (m[i].beats < 2);
    ed = !ev ? 32'd0 : (m[i].beats == 0) ? {2'b10, m[i].tid, m[i].code, m[i].cnt[15:0]}
                                          : m[i].pc;
    check($sformatf("mdl%0d_rep_valid", i), v, ev);
    check($sformatf("mdl%0d_rep_data", i), d, ed);
    check($sformatf("mdl%0d_clr_ex", i), c, m[i].clearing);
    check($sformatf("mdl%0d_thr_killed", i), k, m[i].killed);
    check($sformatf("mdl%0d_ex_cnt", i), n, m[i].cnt[15:0]);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      cmp_model(0, a_rep_valid, a_rep_data, a_clr_ex, a_thr_killed, a_ex_cnt);
      cmp_model(1, b_rep_valid, b_rep_data, b_clr_ex, b_thr_killed, b_ex_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with the handler idle; returns at the first WAIT_CMD negedge.
  task automatic run_report(input logic [5:0] c, input logic [7:0] t, input logic [31:0] p,
                            input logic [15:0] cnt);
    csr_stall = 1'b1; ex_code = c; thr_id = t; epc = p; rep_ready = 1'b1;
    @(negedge clk);
    csr_stall = 1'b0;
    check("hdr_beat", a_rep_data, {2'b10, t, c, cnt});
    check("hdr_valid", a_rep_valid, 1'b1);
    @(negedge clk);
    check("epc_beat", a_rep_data, p);
    @(negedge clk);
    check("valid_drop", a_rep_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; csr_stall = 0; ex_code = '0; thr_id = '0; epc = '0;
    rep_ready = 0; resume = 0; kill = 0;
    m[0] = fresh(); m[1] = fresh();
    repeat (3) @(negedge clk);
    check("rst_rep_valid", a_rep_valid, 1'b0);
    check("rst_rep_data", a_rep_data, 32'd0);
    check("rst_clr_ex", a_clr_ex, 1'b0);
    check("rst_thr_killed", a_thr_killed, 1'b0);
    check("rst_ex_cnt", a_ex_cnt, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single exception: {10, 05, 01, 0000} packs to 8141_0000.
    csr_stall = 1; ex_code = 6'h01; thr_id = 8'h05; epc = 32'h0000_1040; rep_ready = 1;
    @(negedge clk);
    csr_stall = 0;
    check("t1_hdr", a_rep_data, 32'h8141_0000);
    @(negedge clk);
    check("t1_epc", a_rep_data, 32'h0000_1040);
    @(negedge clk);
    check("t1_wait_valid", a_rep_valid, 1'b0);
    resume = 1;
    @(negedge clk);
    resume = 0;
    check("t1_clr_pulse", a_clr_ex, 1'b1);
    @(negedge clk);
    check("t1_clr_end", a_clr_ex, 1'b0);
    check("t1_ex_cnt", a_ex_cnt, 16'd1);

    // Backpressure with inputs changing after capture: {10, 33, 2A, 0001} = 8CEA_0001.
    csr_stall = 1; ex_code = 6'h2A; thr_id = 8'h33; epc = 32'hDEAD_BEEF; rep_ready = 0;
    @(negedge clk);
    csr_stall = 0; ex_code = 6'h3F; thr_id = 8'h00; epc = 32'h0;
    repeat (5) begin
      check("t2_hold_valid", a_rep_valid, 1'b1);
      check("t2_hold_hdr", a_rep_data, 32'h8CEA_0001);
      @(negedge clk);
    end
    rep_ready = 1;
    @(negedge clk);
    check("t2_epc", a_rep_data, 32'hDEAD_BEEF);
    @(negedge clk);
    resume = 1;
    @(negedge clk);
    resume = 0;
    @(negedge clk);
    check("t2_ex_cnt", a_ex_cnt, 16'd2);

    // Saturation and exceptions right after CLEAR.
    force dut_a.ex_cnt = 16'hFFFE;
    force dut_b.ex_cnt = 16'hFFFE;
    m[0].cnt = 16'hFFFE;
    m[1].cnt = 16'hFFFE;
    #1;
    release dut_a.ex_cnt;
    release dut_b.ex_cnt;
    @(negedge clk);
    run_report(6'h10, 8'hA0, 32'h0000_2000, 16'hFFFE);
    resume = 1;
    @(negedge clk);
    resume = 0;
    check("t3_clr", a_clr_ex, 1'b1);
    // Raised during CLEAR: lost that cycle, captured in the following IDLE cycle.
    csr_stall = 1; ex_code = 6'h11; thr_id = 8'hA1; epc = 32'h0000_3000;
    @(negedge clk);
    check("t3_lost_in_clear", a_rep_valid, 1'b0);
    run_report(6'h11, 8'hA1, 32'h0000_3000, 16'hFFFF);
    resume = 1;
    @(negedge clk);
    resume = 0;
    @(negedge clk);
    check("t3_sat_cnt", a_ex_cnt, 16'hFFFF);

    // Kill has priority over resume; stalls are ignored afterwards.
    run_report(6'h3E, 8'h7F, 32'hFFFF_FFFC, 16'hFFFF);
    resume = 1; kill = 1;
    @(negedge clk);
    resume = 0; kill = 0;
    check("t4_killed", a_thr_killed, 1'b1);
    check("t4_no_clr", a_clr_ex, 1'b0);
    csr_stall = 1;
    repeat (4) begin
      @(negedge clk);
      check("t4_parked_valid", a_rep_valid, 1'b0);
      check("t4_parked_killed", a_thr_killed, 1'b1);
    end
    csr_stall = 0;
    do_reset();
    check("t4_rst_killed", a_thr_killed, 1'b0);
    check("t4_rst_cnt", a_ex_cnt, 16'd0);

    // Watchdog: instance a kills after 8 WAIT_CMD cycles, instance b waits forever.
    run_report(6'h05, 8'h09, 32'h0000_4444, 16'h0000);
    repeat (7) begin
      @(negedge clk);
      check("t5_wd_early", a_thr_killed, 1'b0);
    end
    @(negedge clk);
    check("t5_wd_kill", a_thr_killed, 1'b1);
    repeat (1000) @(negedge clk);
    check("t5_nowd_alive", b_thr_killed, 1'b0);
    check("t5_nowd_valid", b_rep_valid, 1'b0);
    resume = 1;
    @(negedge clk);
    resume = 0;
    check("t5_nowd_clr", b_clr_ex, 1'b1);
    check("t5_wd_no_clr", a_clr_ex, 1'b0);
    do_reset();

    // Reset in the middle of the EPC beat.
    csr_stall = 1; ex_code = 6'h22; thr_id = 8'h44; epc = 32'h1234_5678; rep_ready = 1;
    @(negedge clk);
    csr_stall = 0;
    @(negedge clk);
    check("t6_epc_valid", a_rep_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", a_rep_valid, 1'b0);
    check("t6_rst_data", a_rep_data, 32'd0);
    check("t6_rst_cnt", a_ex_cnt, 16'd0);
    check("t6_rst_clr", a_clr_ex, 1'b0);
    check("t6_rst_killed", a_thr_killed, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_idle_valid", a_rep_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
